countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_pkg.sv | 25 ++
 rtl/rise_detect.sv | 30 +++
 rtl/countdown_timer.sv | 135 +++++++++++++
 tb/tb_countdown_timer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and BCD helpers for the countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  function automatic bcd_t bcd_tens(input int value);
    return bcd_t'(value / 10);
  endfunction

  function automatic bcd_t bcd_ones(input int value);
    return bcd_t'(value % 10);
  endfunction

  function automatic int bcd_to_int(input bcd_t tens, input bcd_t ones);
    return int'(tens) * 10 + int'(ones);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; produces one pulse per rise of sig.
// A rise is only recognised once sig has been seen low after reset.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);

  logic sig_q;
  logic armed_q;
  logic pulse_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q   <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sig_q   <= sig;
      armed_q <= armed_q | ~sig;
      pulse_q <= sig & ~sig_q & armed_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/countdown_timer.sv
// BCD seconds countdown timer with start/pause control and done pulse.
// Optional low-time warning output enabled by defining COUNTDOWN_WARN_EN.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int START_SECS = 30,
  parameter int WARN_SECS  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_div,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       running,
  output logic       expired,
`ifdef COUNTDOWN_WARN_EN
  output logic       warn,
`endif
  output logic       done
);

  localparam bcd_t START_TENS = bcd_tens(START_SECS);
  localparam bcd_t START_ONES = bcd_ones(START_SECS);

  state_e state_q;
  bcd_t   tens_q;
  bcd_t   ones_q;
  logic   running_q;
  logic   expired_q;
  logic   done_q;
  logic   tick;

  bcd_t   dec_tens;
  bcd_t   dec_ones;
  logic   dec_last;

  rise_detect u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (clk_div),
    .pulse (tick)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    dec_tens = tens_q;
    dec_ones = ones_q - 4'd1;
    dec_last = (tens_q == 4'd0) && (ones_q == 4'd1);
    if (ones_q == 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tens_q    <= START_TENS;
      ones_q    <= START_ONES;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // start overrides everything, including a coincident tick or pause
      if (start) begin
        state_q   <= RUN;
        tens_q    <= START_TENS;
        ones_q    <= START_ONES;
        running_q <= 1'b1;
        expired_q <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            if (pause) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end else if (tick) begin
              tens_q <= dec_tens;
              ones_q <= dec_ones;
              if (dec_last) begin
                state_q   <= EXPIRED;
                running_q <= 1'b0;
                expired_q <= 1'b1;
                done_q    <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (!pause) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef COUNTDOWN_WARN_EN
  logic warn_q;
  logic warn_hit;
  int   dec_secs;

  always_comb begin
    dec_secs = bcd_to_int(dec_tens, dec_ones);
    warn_hit = (dec_secs != 0) && (dec_secs <= WARN_SECS);
  end

  // Warn only changes when the count changes; it holds through PAUSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warn_q <= 1'b0;
    end else if (start) begin
      warn_q <= 1'b0;
    end else if ((state_q == RUN) && !pause && tick) begin
      warn_q <= warn_hit;
    end
  end

  assign warn = warn_q;
`endif

  assign secs_tens = tens_q;
  assign secs_ones = ones_q;
  assign running   = running_q;
  assign expired   = expired_q;
  assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for countdown_timer (START_SECS=30, WARN_SECS=5).
module tb_countdown_timer;

  localparam int START = 30;
  localparam int WARNS = 5;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       expired;
    logic       done;
    logic       warn;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       clk_div;
  logic       start;
  logic       pause;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;
  logic       running;
  logic       expired;
  logic       done;
  logic       warn_w;

  obs_t exp_q[$];
  int   checks;
  int   errors;
  int   done_cnt;
  int   exp_done_cnt;

  // Reference model state
  int   m_secs;
  logic m_run;
  logic m_paused;
  logic m_exp;

  countdown_timer #(
    .START_SECS (START),
    .WARN_SECS  (WARNS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_div   (clk_div),
    .start     (start),
    .pause     (pause),
    .secs_tens (secs_tens),
    .secs_ones (secs_ones),
    .running   (running),
    .expired   (expired),
`ifdef COUNTDOWN_WARN_EN
    .warn      (warn_w),
`endif
    .done      (done)
  );

`ifndef COUNTDOWN_WARN_EN
  assign warn_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic obs_t model_obs(input logic d);
    obs_t o;
    o.tens    = 4'(m_secs / 10);
    o.ones    = 4'(m_secs % 10);
    o.running = m_run;
    o.expired = m_exp;
    o.done    = d;
`ifdef COUNTDOWN_WARN_EN
    o.warn    = (m_run || m_paused) && (m_secs > 0) && (m_secs <= WARNS);
`else
    o.warn    = 1'b0;
`endif
    return o;
  endfunction

  task automatic push(input logic d);
    exp_q.push_back(model_obs(d));
    if (d) exp_done_cnt++;
  endtask

  task automatic compare(input string tag);
    obs_t e;
    obs_t a;
    a = {secs_tens, secs_ones, running, expired, done, warn_w};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, a);
    end else begin
      e = exp_q.pop_front();
      assert (a === e) else begin
        errors++;
        $error("FAIL %s: observed tens=%0d ones=%0d run=%b exp=%b done=%b warn=%b, expected tens=%0d ones=%0d run=%b exp=%b done=%b warn=%b",
               tag, a.tens, a.ones, a.running, a.expired, a.done, a.warn,
               e.tens, e.ones, e.running, e.expired, e.done, e.warn);
      end
    end
  endtask

  // One clk_div rising edge; ends at the negedge after the count update.
  task automatic do_tick(input string tag);
    logic d;
    d = 1'b0;
    if (m_run) begin
      if (m_secs == 1) begin
        m_secs = 0;
        m_run  = 1'b0;
        m_exp  = 1'b1;
        d      = 1'b1;
      end else begin
        m_secs--;
      end
    end
    push(d);
    @(negedge clk) clk_div = 1'b1;
    @(negedge clk) clk_div = 1'b0;
    @(negedge clk);
    compare(tag);
  endtask

  task automatic idle_check(input string tag);
    push(1'b0);
    @(negedge clk);
    compare(tag);
  endtask

  task automatic do_start(input string tag);
    @(negedge clk) start = 1'b1;
    m_secs = START; m_run = 1'b1; m_paused = 1'b0; m_exp = 1'b0;
    push(1'b0);
    @(negedge clk) start = 1'b0;
    compare(tag);
  endtask

  task automatic ticks_to(input int target, input string tag);
    while (m_secs > target) do_tick(tag);
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0; exp_done_cnt = 0;
    m_secs = START; m_run = 1'b0; m_paused = 1'b0; m_exp = 1'b0;
    rst_n = 1'b0; clk_div = 1'b1; start = 1'b0; pause = 1'b0;

    repeat (3) @(negedge clk);
    push(1'b0);
    compare("reset_state");

    // Release reset with clk_div already high: no tick may follow.
    rst_n = 1'b1;
    start = 1'b1;
    m_run = 1'b1;
    push(1'b0);
    @(negedge clk) start = 1'b0;
    compare("start_after_reset");
    idle_check("no_tick_high_at_release_1");
    idle_check("no_tick_high_at_release_2");
    clk_div = 1'b0;
    idle_check("clk_div_low");

    // Full countdown 30 -> 00
    for (int i = 0; i < START; i++) do_tick($sformatf("countdown_%0d", START - 1 - i));
    idle_check("expired_hold");
    do_tick("tick_in_expired");

    // Restart from EXPIRED; BCD borrow cases 20->19 and 10->09
    do_start("start_from_expired");
    ticks_to(20, "to_20");
    do_tick("bcd_20_to_19");
    ticks_to(10, "to_10");
    do_tick("bcd_10_to_09");

    // Pause at 17 with ticks ignored
    do_start("restart");
    ticks_to(17, "to_17");
    @(negedge clk) pause = 1'b1;
    m_run = 1'b0; m_paused = 1'b1;
    push(1'b0);
    @(negedge clk);
    compare("pause_enter");
    for (int i = 0; i < 5; i++) do_tick("tick_while_paused");
    @(negedge clk) pause = 1'b0;
    m_run = 1'b1; m_paused = 1'b0;
    push(1'b0);
    @(negedge clk);
    compare("pause_exit");
    do_tick("tick_after_pause_16");

    // Pause and tick in the same cycle: tick dropped
    @(negedge clk) clk_div = 1'b1;
    @(negedge clk) begin clk_div = 1'b0; pause = 1'b1; end
    m_run = 1'b0; m_paused = 1'b1;
    push(1'b0);
    @(negedge clk);
    compare("pause_with_tick");
    @(negedge clk) pause = 1'b0;
    m_run = 1'b1; m_paused = 1'b0;
    push(1'b0);
    @(negedge clk);
    compare("resume_after_pause_tick");

    // Start and tick in the same cycle at 12: reload wins
    ticks_to(12, "to_12");
    @(negedge clk) clk_div = 1'b1;
    @(negedge clk) begin clk_div = 1'b0; start = 1'b1; end
    m_secs = START; m_run = 1'b1;
    push(1'b0);
    @(negedge clk) start = 1'b0;
    compare("start_with_tick");
    idle_check("start_with_tick_hold");

    // Asynchronous reset between edges at 08
    ticks_to(8, "to_08");
    #2 rst_n = 1'b0;
    m_secs = START; m_run = 1'b0; m_paused = 1'b0; m_exp = 1'b0;
    push(1'b0);
    #1 compare("async_reset_immediate");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_tick("tick_in_idle_after_reset");

    checks++;
    assert (done_cnt === exp_done_cnt) else begin
      errors++;
      $error("FAIL done_count: observed %0d expected %0d", done_cnt, exp_done_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
